// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: constants shared by the fetch, decode and execute stages.
package fetch_unit_pkg;
    localparam int unsigned RESET_PC_DEFAULT = 0;
    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam int          INSTR_BYTES      = 4;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of {pc, instruction} entries with flush.
// Ports: push/push_data write the tail, pop retires the head, flush empties,
// head is the oldest entry, count is the occupancy. Async active-high reset.
module fetch_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = flush ? '0 : push ? nxt(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = flush ? '0 : pop ? nxt(rd_ptr_q) : rd_ptr_q;
        count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
        head     = mem_q[rd_ptr_q];
        count    = count_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push && !flush) mem_q[wr_ptr_q] <= push_data;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding {PC, instruction} pairs to decode.
// Ports: imem_req_* request channel to instruction memory, imem_resp_* in-order
// responses, redirect_* branch/jump target from execute, out_* decode handshake.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                      ADDRESS_BITS = 32,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = ADDRESS_BITS'(RESET_PC_DEFAULT),
    parameter int                      DEPTH        = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    imem_req_valid,
    output logic [ADDRESS_BITS-1:0] imem_req_addr,
    input  logic                    imem_req_ready,
    input  logic                    imem_resp_valid,
    input  logic [31:0]             imem_resp_data,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_BITS-1:0] redirect_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDRESS_BITS-1:0] out_PC,
    output logic [31:0]             out_instruction
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = ADDRESS_BITS + 32;

    logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target;
    logic [CW-1:0]           inflight_q, inflight_d, drop_cnt_q, drop_cnt_d, count;
    logic                    req_fire, resp_ok, push, pop;
    logic [EW-1:0]           head;

    always_comb begin
        target          = redirect_pc & ~ADDRESS_BITS'(3);
        // Credit: in-flight requests (including ones to be dropped) plus buffered entries never exceed DEPTH.
        imem_req_valid  = !reset && !redirect_valid && (int'(inflight_q) + int'(count) < DEPTH);
        imem_req_addr   = fetch_pc_q;
        req_fire        = imem_req_valid && imem_req_ready;
        // A response with nothing in flight is a protocol error and is ignored.
        resp_ok         = imem_resp_valid && inflight_q != '0;
        push            = resp_ok && drop_cnt_q == '0 && !redirect_valid;
        out_valid       = count != '0 && !redirect_valid;
        pop             = out_valid && out_ready;
        inflight_d      = inflight_q + CW'(req_fire) - CW'(resp_ok);
        // On redirect every request still outstanding after this cycle belongs to the old stream.
        drop_cnt_d      = redirect_valid ? inflight_q - CW'(resp_ok)
                                         : drop_cnt_q - CW'(resp_ok && drop_cnt_q != '0);
        fetch_pc_d      = redirect_valid ? target
                        : req_fire ? fetch_pc_q + ADDRESS_BITS'(INSTR_BYTES) : fetch_pc_q;
        resp_pc_d       = redirect_valid ? target
                        : push ? resp_pc_q + ADDRESS_BITS'(INSTR_BYTES) : resp_pc_q;
        out_PC          = head[EW-1:32];
        out_instruction = head[31:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_buffer #(.WIDTH(EW), .DEPTH(DEPTH)) u_buf (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({resp_pc_q, imem_resp_data}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit against a queue-based model.
module tb_fetch_unit;
    localparam int DEPTH = 2;

    logic        clock = 0, reset = 1;
    logic        imem_req_valid, imem_req_ready = 0, imem_resp_valid = 0;
    logic [31:0] imem_req_addr, imem_resp_data = 0;
    logic        redirect_valid = 0, out_valid, out_ready = 0;
    logic [31:0] redirect_pc = 0, out_PC, out_instruction;

    fetch_unit #(.ADDRESS_BITS(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_PC          (out_PC),
        .out_instruction (out_instruction)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] sb[$];
    logic [31:0] mpc = 0;
    int          cyc = 0, cur_lmax = 1, checks = 0, errors = 0, pops = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h00B5_0533;
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", n, cyc, act, exp);
        end
    endtask

    task automatic step(input int rdy, input int ord, input int lmax, input int rp);
        int sel;
        @(posedge clock);
        #1;
        cyc++;
        cur_lmax = lmax;
        imem_req_ready = $urandom_range(99) < rdy;
        out_ready = $urandom_range(99) < ord;
        redirect_valid = !reset && ($urandom_range(99) < rp);
        sel = $urandom_range(3);
        redirect_pc = sel == 0 ? 32'h103 : sel == 1 ? 32'hFFFF_FFF8 : sel == 2 ? 32'h200 : $urandom;
        imem_resp_valid = !reset && pend.size() > 0 && pend[0].due <= cyc;
        imem_resp_data = imem_resp_valid ? mem(pend[0].addr) : $urandom;
    endtask

    always @(negedge clock) begin
        if (reset) begin
            pend.delete();
            sb.delete();
            mpc = 0;
        end else begin
            chk("req_valid", 64'(imem_req_valid), 64'(!redirect_valid && (pend.size() + sb.size() < DEPTH)));
            chk("out_valid", 64'(out_valid), 64'(sb.size() != 0 && !redirect_valid));
            if (imem_req_valid) chk("req_addr", 64'(imem_req_addr), 64'(mpc));
            if (out_valid && out_ready && sb.size() > 0 && !redirect_valid) begin
                chk("out_pc", 64'(out_PC), 64'(sb[0]));
                chk("out_instr", 64'(out_instruction), 64'(mem(sb[0])));
                void'(sb.pop_front());
                pops++;
            end
            if (imem_resp_valid && pend.size() > 0) begin
                pend_t p;
                p = pend.pop_front();
                if (p.live && !redirect_valid) sb.push_back(p.addr);
            end
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back('{addr: mpc, due: cyc + int'($urandom_range(cur_lmax, 1)), live: 1'b1});
                mpc = mpc + 32'd4;
            end
            if (redirect_valid) begin
                sb.delete();
                foreach (pend[i]) pend[i].live = 1'b0;
                mpc = {redirect_pc[31:2], 2'b00};
            end
        end
    end

    initial begin
        repeat (3) step(100, 100, 1, 0);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_req_addr", 64'(imem_req_addr), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", 64'(out_PC), 64'd0);
        chk("rst_out_instr", 64'(out_instruction), 64'd0);
        reset = 0;
        repeat (20) step(100, 100, 1, 0);
        repeat (12) step(100, 0, 1, 0);
        repeat (10) step(100, 100, 1, 0);
        repeat (300) step(70, 70, 3, 3);
        repeat (300) step(100, 90, 4, 10);
        repeat (300) step(50, 50, 2, 20);
        repeat (12) step(100, 0, 2, 0);
        chk("full_before_reset", 64'(out_valid), 64'd1);
        @(posedge clock);
        #3;
        reset = 1;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_req_valid", 64'(imem_req_valid), 64'd0);
        chk("async_out_pc", 64'(out_PC), 64'd0);
        repeat (2) step(100, 100, 1, 0);
        reset = 0;
        #1;
        chk("restart_addr", 64'(imem_req_addr), 64'd0);
        repeat (200) step(80, 80, 3, 5);
        chk("progress", 64'(pops > 100), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
